// File: rtl/switch_allocator.sv
// -----------------------------------------------------------------------------
// switch_allocator
// Separable 5x5 switch allocator for one mesh router. It routes each input's
// head destination with XY dimension order. It then arbitrates each output
// round-robin among the inputs that request it. A grant is held for the whole
// packet (wormhole lock), and the allocator drives the crossbar select for
// each output.
// Port index everywhere: 0=Local 1=North 2=East 3=South 4=West.
//
// Ports
//   clk        : clock, all state on the rising edge
//   rst        : asynchronous reset, active-low
//   req        : req[i], input unit i wants its routed output
//   dest       : destination address of the packet at the head of unit i
//   flit_valid : unit i presents a flit this cycle
//   flit_tail  : the flit presented by unit i is the packet tail
//   out_ready  : downstream of output o accepts a flit this cycle
//   gnt        : gnt[i], unit i owns its routed output (registered)
//   xbar_sel   : input index driven onto output o, 3'd7 = none (registered)
//   out_valid  : flit on output o is valid (combinational)
//   in_fire    : flit of unit i is transferred this cycle (combinational)
// -----------------------------------------------------------------------------
module switch_allocator #(
    parameter int unsigned ADDRESS_SIZE = 4,
    parameter int unsigned X_COORD      = 0,
    parameter int unsigned Y_COORD      = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [4:0]                    req,
    input  logic [4:0][ADDRESS_SIZE-1:0]  dest,
    input  logic [4:0]                    flit_valid,
    input  logic [4:0]                    flit_tail,
    input  logic [4:0]                    out_ready,
    output logic [4:0]                    gnt,
    output logic [4:0][2:0]               xbar_sel,
    output logic [4:0]                    out_valid,
    output logic [4:0]                    in_fire
);

    localparam int unsigned NP   = 5;
    localparam int unsigned PW   = 3;
    localparam int unsigned HALF = ADDRESS_SIZE / 2;

    localparam logic [HALF-1:0] X_C = HALF'(X_COORD);
    localparam logic [HALF-1:0] Y_C = HALF'(Y_COORD);

    localparam logic [PW-1:0] P_LOCAL = 3'd0;
    localparam logic [PW-1:0] P_NORTH = 3'd1;
    localparam logic [PW-1:0] P_EAST  = 3'd2;
    localparam logic [PW-1:0] P_SOUTH = 3'd3;
    localparam logic [PW-1:0] P_WEST  = 3'd4;
    localparam logic [PW-1:0] P_NONE  = 3'd7;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } own_state_t;

    own_state_t                r_state [NP];
    logic [NP-1:0][PW-1:0]     r_xbar;
    logic [NP-1:0][PW-1:0]     r_ptr;
    logic [NP-1:0]             r_gnt;

    logic [NP-1:0][HALF-1:0]   w_dx;
    logic [NP-1:0][HALF-1:0]   w_dy;
    logic [NP-1:0][PW-1:0]     w_route;
    logic [NP-1:0][NP-1:0]     w_cand;
    logic [NP-1:0]             w_pick_vld;
    logic [NP-1:0][PW-1:0]     w_pick;
    logic [NP-1:0]             w_out_valid;
    logic [NP-1:0]             w_in_fire;
    logic [NP-1:0]             w_release;

    // XY dimension-order route of every input's current destination
    always_comb begin
        w_dx    = '0;
        w_dy    = '0;
        w_route = '0;
        for (int unsigned i = 0; i < NP; i++) begin
            w_dx[i] = dest[i][ADDRESS_SIZE-1:HALF];
            w_dy[i] = dest[i][HALF-1:0];
            if (w_dx[i] > X_C)
                w_route[i] = P_EAST;
            else if (w_dx[i] < X_C)
                w_route[i] = P_WEST;
            else if (w_dy[i] > Y_C)
                w_route[i] = P_SOUTH;
            else if (w_dy[i] < Y_C)
                w_route[i] = P_NORTH;
            else
                w_route[i] = P_LOCAL;
        end
    end

    // Per-output candidate sets and round-robin pick starting at the pointer
    always_comb begin
        w_cand     = '0;
        w_pick_vld = '0;
        w_pick     = '0;
        for (int unsigned o = 0; o < NP; o++) begin
            for (int unsigned i = 0; i < NP; i++) begin
                w_cand[o][i] = req[i] & (w_route[i] == PW'(o)) & ~r_gnt[i];
            end
        end
        for (int unsigned o = 0; o < NP; o++) begin
            for (int unsigned off = 0; off < NP; off++) begin
                for (int unsigned i = 0; i < NP; i++) begin
                    if (!w_pick_vld[o] && w_cand[o][i] &&
                        (((32'(r_ptr[o]) + off) % NP) == i)) begin
                        w_pick_vld[o] = 1'b1;
                        w_pick[o]     = PW'(i);
                    end
                end
            end
        end
    end

    // Transfer and release conditions for locked outputs
    always_comb begin
        w_out_valid = '0;
        w_in_fire   = '0;
        w_release   = '0;
        for (int unsigned o = 0; o < NP; o++) begin
            if (r_state[o] == S_LOCKED) begin
                for (int unsigned i = 0; i < NP; i++) begin
                    if (r_xbar[o] == PW'(i)) begin
                        w_out_valid[o] = r_gnt[i] & flit_valid[i] & out_ready[o];
                        w_in_fire[i]   = w_out_valid[o];
                        // tail leaves, or the owner abandons its request
                        w_release[o]   = (w_out_valid[o] & flit_tail[i]) | ~req[i];
                    end
                end
            end
        end
    end

    // Per-output ownership FSMs; the grant vector and crossbar selects move with them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned o = 0; o < NP; o++) begin
                r_state[o] <= S_IDLE;
            end
            r_xbar <= '1;
            r_ptr  <= '0;
            r_gnt  <= '0;
        end else begin
            for (int unsigned o = 0; o < NP; o++) begin
                case (r_state[o])
                    S_IDLE: begin
                        if (w_pick_vld[o]) begin
                            r_state[o] <= S_LOCKED;
                            r_xbar[o]  <= w_pick[o];
                            r_ptr[o]   <= (w_pick[o] == PW'(NP - 1)) ? '0
                                                                     : PW'(w_pick[o] + 3'd1);
                            for (int unsigned i = 0; i < NP; i++) begin
                                if (w_pick[o] == PW'(i))
                                    r_gnt[i] <= 1'b1;
                            end
                        end
                    end
                    S_LOCKED: begin
                        if (w_release[o]) begin
                            r_state[o] <= S_IDLE;
                            r_xbar[o]  <= P_NONE;
                            for (int unsigned i = 0; i < NP; i++) begin
                                if (r_xbar[o] == PW'(i))
                                    r_gnt[i] <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state[o] <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign gnt       = r_gnt;
    assign xbar_sel  = r_xbar;
    assign out_valid = w_out_valid;
    assign in_fire   = w_in_fire;

endmodule
